module_sevenseg_capture: RTL and testbench
==========================================

// Module: module_sevenseg_capture
//
// PURPOSE
// - Receiving end of the multiplexed seven-segment display interface: samples a scanned segment bus plus
//   digit-select lines and rebuilds the 4-bit hex value held on each digit position.
// - Used as a loop-back checker and display monitor: sits beside the display driver and turns its
//   pin-level output back into per-digit hex values, valid flags and error flags.
//
// PARAMETERS
// - N_DIGITS       4   number of scanned digit positions (>=1)
// - STABLE_CYCLES  4   consecutive identical samples required before capture (>=1)
//
// PORTS
// - clk            in   1           system clock
// - rst_n          in   1           reset: asynchronous assert, active-low; sole reset, one clock domain
// - seg_i          in   7           segment bus, active-high: bit0=a .. bit6=g
// - an_i           in   N_DIGITS    digit select, active-low, one-hot when a digit is driven
// - err_clr_i      in   1           clears err_o (synchronous, level)
// - digits_o       out  4*N_DIGITS  captured hex values; digit i in [4i+3:4i]
// - digit_valid_o  out  N_DIGITS    digit i currently holds a decoded hex value
// - update_o       out  1           one-cycle pulse when a capture writes a digit register
// - update_idx_o   out  $clog2(N_DIGITS) (min 1)  index written; meaningful only while update_o=1
// - err_o          out  1           sticky: undecodable non-blank pattern seen
//
// BEHAVIOUR
// - Reset, at any time including mid-capture: all outputs 0, sync flops 0, FSM=IDLE, counter 0.
// - Input path: seg_i and an_i each pass through a 2-flop synchronizer. Sampled pair is S = {an, seg}.
// - Decode (pattern -> hex): segment encoding a..g, bit0=a.
//   0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//   Pattern 00 is BLANK. Any other pattern is INVALID.
// - FSM states: IDLE, TRACK, HOLD.
//   - IDLE: used while an is not exactly one-hot-low (all high or multi-low); counter=0.
//     Go to TRACK, counter=0, on the first one-hot sample.
//   - TRACK: if S equals the previous S, counter++. If S differs: counter=0, stay in TRACK
//     (or go to IDLE if not one-hot).
//     When counter reaches STABLE_CYCLES-1 with S unchanged, capture and go to HOLD.
//   - HOLD: no further captures while S is unchanged. Any change in S goes to TRACK (counter=0),
//     or to IDLE if not one-hot.
// - Capture at index i (the low bit of an):
//   - Valid hex: digits_o[i] <= hex, digit_valid_o[i] <= 1, update_o=1, update_idx_o=i.
//   - BLANK: digit_valid_o[i] <= 0, digits_o[i] unchanged, update_o=1.
//   - INVALID: digit_valid_o[i] <= 0, err_o <= 1, update_o=0.
// - Latency: a pair applied before edge k and held is captured at edge k+2+STABLE_CYCLES.
//   update_o is high in the following cycle.
// - update_o and update_idx_o are registered; update_o is never high two cycles in a row for the same S.
// - err_o: set by INVALID capture, cleared by err_clr_i. A same-cycle set and clear leaves err_o=1.
// - Counter width $clog2(STABLE_CYCLES+1); the counter saturates and never wraps.
// - Other digit registers are untouched by a capture at index i.
//
// STRUCTURE
// - sevenseg_pkg (shared with the display encoder):
//   - SEG_0..SEG_F and SEG_BLANK 7-bit localparams.
//   - function seg_to_hex(seg) -> {valid, blank, hex[3:0]}.
//   - typedef enum logic [1:0] {IDLE, TRACK, HOLD} cap_state_t.
// - Sub-module module_sevenseg_decode: combinational 7->{valid,blank,hex} reverse lookup built on the
//   package function.
// - Top holds the synchronizer, FSM, counter, digit register file and error flag.
//
// TESTING
// 1. Reset, then an_i=1110, seg_i=5B held 10 cycles -> update_o once at edge 7 (STABLE_CYCLES=4),
//    update_idx_o=0, digits_o[3:0]=2, digit_valid_o=0001.
// 2. All 16 hex patterns on digit 2 (an_i=1011), each held 8 cycles -> digits_o[11:8] follows 0..F,
//    16 update pulses, err_o=0.
// 3. seg_i toggling 3F/06 every 2 cycles on digit 1 -> no update_o ever. Then hold 06 -> one capture,
//    digits_o[7:4]=1.
// 4. an_i=1100 or 1111 with seg_i=7F for 20 cycles -> no update, FSM stays IDLE. Then seg_i=00 on digit 0
//    after a valid 8 -> digit_valid_o[0]=0, update_o pulses.
// 5. seg_i=01 (INVALID) on digit 3 -> err_o=1, update_o=0, digit_valid_o[3]=0. Assert err_clr_i in the
//    same cycle as a second INVALID capture -> err_o stays 1. A later lone err_clr_i -> err_o=0.
// 6. Drop rst_n mid-TRACK (counter=2) -> all outputs 0 immediately. After release, a fresh
//    STABLE_CYCLES+2 hold is required before capture.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: segment patterns, reverse lookup and the
// capture FSM state type.
package sevenseg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} cap_state_t;

    // Returns {valid, blank, hex}; both flags low means an undecodable pattern.
    function automatic logic [5:0] seg_to_hex(input logic [6:0] seg);
        logic [5:0] r;
        r = 6'b000000;
        case (seg)
            SEG_0:     r = {2'b10, 4'h0};
            SEG_1:     r = {2'b10, 4'h1};
            SEG_2:     r = {2'b10, 4'h2};
            SEG_3:     r = {2'b10, 4'h3};
            SEG_4:     r = {2'b10, 4'h4};
            SEG_5:     r = {2'b10, 4'h5};
            SEG_6:     r = {2'b10, 4'h6};
            SEG_7:     r = {2'b10, 4'h7};
            SEG_8:     r = {2'b10, 4'h8};
            SEG_9:     r = {2'b10, 4'h9};
            SEG_A:     r = {2'b10, 4'hA};
            SEG_B:     r = {2'b10, 4'hB};
            SEG_C:     r = {2'b10, 4'hC};
            SEG_D:     r = {2'b10, 4'hD};
            SEG_E:     r = {2'b10, 4'hE};
            SEG_F:     r = {2'b10, 4'hF};
            SEG_BLANK: r = {2'b01, 4'h0};
            default:   r = 6'b000000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/module_sevenseg_capture_if.sv
// Pin-level display bus plus the capture results and FSM debug state.
// update_o is a single-cycle strobe with no back-pressure: update_idx_o is
// qualified by update_o and must be consumed in the cycle it is high.
interface module_sevenseg_capture_if #(
    parameter int N_DIGITS = 4
);
    import sevenseg_pkg::*;

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [6:0]            seg_i;
    logic [N_DIGITS-1:0]   an_i;
    logic                  err_clr_i;
    logic [4*N_DIGITS-1:0] digits_o;
    logic [N_DIGITS-1:0]   digit_valid_o;
    logic                  update_o;
    logic [IDX_W-1:0]      update_idx_o;
    logic                  err_o;
    cap_state_t            state_dbg;

    modport master (
        output seg_i, an_i, err_clr_i,
        input  digits_o, digit_valid_o, update_o, update_idx_o, err_o, state_dbg
    );

    modport slave (
        input  seg_i, an_i, err_clr_i,
        output digits_o, digit_valid_o, update_o, update_idx_o, err_o, state_dbg
    );

endinterface

// File: rtl/module_sevenseg_decode.sv
// Combinational reverse lookup from a segment pattern to {valid, blank, hex}.
module module_sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic       blank,
    output logic [3:0] hex
);

    assign {valid, blank, hex} = seg_to_hex(seg);

endmodule

// File: rtl/module_sevenseg_capture.sv
// Rebuilds per-digit hex values from a scanned seven-segment bus: synchronise,
// wait for a stable one-hot sample, then write the selected digit register.
module module_sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    module_sevenseg_capture_if.slave bus
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CW    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

    logic [N_DIGITS-1:0]   an_s1, an_s2;
    logic [6:0]            seg_s1, seg_s2;
    logic [N_DIGITS+6:0]   s_prev;
    logic [N_DIGITS-1:0]   an_low;
    logic                  one_hot, changed, capture;
    logic [IDX_W-1:0]      sel_idx;
    logic                  dec_valid, dec_blank;
    logic [3:0]            dec_hex;
    cap_state_t            state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [4*N_DIGITS-1:0] digits_q;
    logic [N_DIGITS-1:0]   valid_q;
    logic                  upd_q, err_q;
    logic [IDX_W-1:0]      upd_idx_q;

    assign an_low  = ~an_s2;
    assign one_hot = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
    assign changed = ({an_s2, seg_s2} != s_prev);

    // Lowest driven (low) digit-select line gives the capture index.
    always_comb begin
        sel_idx = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (!an_s2[i]) sel_idx = IDX_W'(i);
        end
    end

    module_sevenseg_decode u_decode (
        .seg   (seg_s2),
        .valid (dec_valid),
        .blank (dec_blank),
        .hex   (dec_hex)
    );

    // Two-flop synchronisers and the previous-sample register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s1  <= '0;
            an_s2  <= '0;
            seg_s1 <= '0;
            seg_s2 <= '0;
            s_prev <= '0;
        end else begin
            an_s1  <= bus.an_i;
            an_s2  <= an_s1;
            seg_s1 <= bus.seg_i;
            seg_s2 <= seg_s1;
            s_prev <= {an_s2, seg_s2};
        end
    end

    // FSM state and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: restart the count on any change, capture once per stable run.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (one_hot) state_n = TRACK;
            end
            TRACK: begin
                if (changed) begin
                    cnt_n   = '0;
                    state_n = one_hot ? TRACK : IDLE;
                end else if (cnt >= CNT_LAST) begin
                    capture = 1'b1;
                    state_n = HOLD;
                end else begin
                    cnt_n = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
                end
            end
            HOLD: begin
                if (changed) begin
                    cnt_n   = '0;
                    state_n = one_hot ? TRACK : IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Digit register file, update strobe and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q  <= '0;
            valid_q   <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
            err_q     <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (capture) begin
                if (dec_valid) begin
                    digits_q[{sel_idx, 2'b00} +: 4] <= dec_hex;
                    valid_q[sel_idx]                <= 1'b1;
                    upd_q                           <= 1'b1;
                    upd_idx_q                       <= sel_idx;
                end else if (dec_blank) begin
                    valid_q[sel_idx] <= 1'b0;
                    upd_q            <= 1'b1;
                    upd_idx_q        <= sel_idx;
                end else begin
                    valid_q[sel_idx] <= 1'b0;
                end
            end
            if (capture && !dec_valid && !dec_blank) begin
                err_q <= 1'b1;
            end else if (bus.err_clr_i) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.digits_o      = digits_q;
    assign bus.digit_valid_o = valid_q;
    assign bus.update_o      = upd_q;
    assign bus.update_idx_o  = upd_idx_q;
    assign bus.err_o         = err_q;
    assign bus.state_dbg     = state;

endmodule

// File: tb/tb_module_sevenseg_capture.sv
// Bench for the seven-segment capture block: directed scenarios plus random
// scanning, checked every cycle against a run-length reference model.
module tb_module_sevenseg_capture;
    import sevenseg_pkg::*;

    localparam int N      = 4;
    localparam int STABLE = 4;
    localparam int SW     = N + 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   upd_count = 0;
    int   base;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    module_sevenseg_capture_if #(.N_DIGITS(N)) bus ();

    module_sevenseg_capture #(.N_DIGITS(N), .STABLE_CYCLES(STABLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic hold(input logic [N-1:0] an, input logic [6:0] seg, input int n, input logic clr);
        @(negedge clk);
        bus.an_i      = an;
        bus.seg_i     = seg;
        bus.err_clr_i = clr;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: what the bus pins look like after the 2-cycle
    // synchroniser, how long the current sample has been unchanged, and the
    // resulting register contents.
    logic [SW-1:0]  m_p1 = '0, m_p2 = '0, m_prev = '0, m_s;
    int             m_run = 1;
    logic [4*N-1:0] m_dig = '0;
    logic [N-1:0]   m_val = '0;
    logic           m_upd = 1'b0, m_err = 1'b0, m_set;
    int             m_idx = 0;
    int             m_hex, m_zeros, m_low;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p1 = '0; m_p2 = '0; m_prev = '0; m_run = 1;
            m_dig = '0; m_val = '0; m_upd = 1'b0; m_err = 1'b0; m_idx = 0;
        end else begin
            m_s  = m_p2;
            m_p2 = m_p1;
            m_p1 = {bus.an_i, bus.seg_i};
            if (m_s == m_prev) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run = 1;
            end
            m_prev = m_s;
            m_upd  = 1'b0;
            m_set  = 1'b0;
            m_zeros = 0;
            m_low   = -1;
            for (int i = 0; i < N; i++) begin
                if (!m_s[7+i]) begin
                    m_zeros++;
                    if (m_low < 0) m_low = i;
                end
            end
            if (m_zeros == 1 && m_run == STABLE + 1) begin
                m_hex = -1;
                for (int h = 0; h < 16; h++) if (seg_tab[h] == m_s[6:0]) m_hex = h;
                if (m_hex >= 0) begin
                    m_dig[4*m_low +: 4] = 4'(m_hex);
                    m_val[m_low] = 1'b1;
                    m_upd = 1'b1;
                    m_idx = m_low;
                end else if (m_s[6:0] == 7'h00) begin
                    m_val[m_low] = 1'b0;
                    m_upd = 1'b1;
                    m_idx = m_low;
                end else begin
                    m_val[m_low] = 1'b0;
                    m_set = 1'b1;
                end
            end
            if (m_set) m_err = 1'b1;
            else if (bus.err_clr_i) m_err = 1'b0;
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("digits", 32'(bus.digits_o), 32'(m_dig));
            check("valid", 32'(bus.digit_valid_o), 32'(m_val));
            check("update", 32'(bus.update_o), 32'(m_upd));
            check("err", 32'(bus.err_o), 32'(m_err));
            if (m_upd) check("update_idx", 32'(bus.update_idx_o), 32'(m_idx));
            if (bus.update_o) upd_count++;
        end
    end

    initial begin
        bus.an_i      = '1;
        bus.seg_i     = '0;
        bus.err_clr_i = 1'b0;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_digits", 32'(bus.digits_o), 32'h0);
        check("rst_valid", 32'(bus.digit_valid_o), 32'h0);
        check("rst_update", 32'(bus.update_o), 32'h0);
        check("rst_err", 32'(bus.err_o), 32'h0);
        check("rst_state", 32'(bus.state_dbg), 32'(IDLE));
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // 1: digit 0 shows "2"; capture on the 7th edge after the pattern appears.
        @(negedge clk);
        bus.an_i  = 4'b1110;
        bus.seg_i = 7'h5B;
        repeat (6) @(posedge clk);
        #1 check("t1_no_update_yet", 32'(bus.update_o), 32'h0);
        @(posedge clk); #1;
        check("t1_update", 32'(bus.update_o), 32'h1);
        check("t1_idx", 32'(bus.update_idx_o), 32'h0);
        check("t1_digit0", 32'(bus.digits_o[3:0]), 32'h2);
        check("t1_valid", 32'(bus.digit_valid_o), 32'b0001);
        @(posedge clk); #1;
        check("t1_update_once", 32'(bus.update_o), 32'h0);
        repeat (2) @(posedge clk);

        // 2: all sixteen patterns on digit 2.
        base = upd_count;
        for (int h = 0; h < 16; h++) begin
            hold(4'b1011, seg_tab[h], 8, 1'b0);
            check("t2_digit2", 32'(bus.digits_o[11:8]), 32'(h));
        end
        check("t2_pulses", 32'(upd_count - base), 32'd16);
        check("t2_err", 32'(bus.err_o), 32'h0);

        // 3: toggling faster than the stability window never captures.
        base = upd_count;
        for (int j = 0; j < 5; j++) begin
            hold(4'b1101, 7'h3F, 2, 1'b0);
            hold(4'b1101, 7'h06, 2, 1'b0);
        end
        check("t3_no_update", 32'(upd_count - base), 32'd0);
        hold(4'b1101, 7'h06, 8, 1'b0);
        check("t3_digit1", 32'(bus.digits_o[7:4]), 32'h1);
        check("t3_one_pulse", 32'(upd_count - base), 32'd1);

        // 4: non-one-hot selects are ignored; blank clears the valid flag.
        base = upd_count;
        hold(4'b1100, 7'h7F, 20, 1'b0);
        check("t4_idle_multi", 32'(bus.state_dbg), 32'(IDLE));
        hold(4'b1111, 7'h7F, 20, 1'b0);
        check("t4_idle_none", 32'(bus.state_dbg), 32'(IDLE));
        check("t4_no_update", 32'(upd_count - base), 32'd0);
        hold(4'b1110, 7'h7F, 8, 1'b0);
        check("t4_digit0_8", 32'(bus.digits_o[3:0]), 32'h8);
        check("t4_valid0_set", 32'(bus.digit_valid_o[0]), 32'h1);
        hold(4'b1110, 7'h00, 8, 1'b0);
        check("t4_valid0_clr", 32'(bus.digit_valid_o[0]), 32'h0);
        check("t4_digit0_kept", 32'(bus.digits_o[3:0]), 32'h8);
        check("t4_pulses", 32'(upd_count - base), 32'd2);

        // 5: invalid pattern sets err; set beats a simultaneous clear.
        base = upd_count;
        hold(4'b0111, 7'h01, 8, 1'b0);
        check("t5_err_set", 32'(bus.err_o), 32'h1);
        check("t5_valid3", 32'(bus.digit_valid_o[3]), 32'h0);
        check("t5_no_update", 32'(upd_count - base), 32'd0);
        @(negedge clk);
        bus.seg_i = 7'h02;
        repeat (6) @(negedge clk);
        bus.err_clr_i = 1'b1;
        @(negedge clk);
        bus.err_clr_i = 1'b0;
        check("t5_set_wins", 32'(bus.err_o), 32'h1);
        @(negedge clk);
        bus.err_clr_i = 1'b1;
        @(negedge clk);
        bus.err_clr_i = 1'b0;
        check("t5_err_cleared", 32'(bus.err_o), 32'h0);

        // 6: reset in the middle of tracking, then a full fresh hold.
        @(negedge clk);
        bus.an_i  = 4'b1110;
        bus.seg_i = 7'h4F;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_digits", 32'(bus.digits_o), 32'h0);
        check("t6_rst_valid", 32'(bus.digit_valid_o), 32'h0);
        check("t6_rst_update", 32'(bus.update_o), 32'h0);
        check("t6_rst_state", 32'(bus.state_dbg), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("t6_no_early_capture", 32'(bus.update_o), 32'h0);
        @(posedge clk); #1;
        check("t6_capture", 32'(bus.update_o), 32'h1);
        check("t6_digit0", 32'(bus.digits_o[3:0]), 32'h3);

        // Random scanning traffic.
        for (int it = 0; it < 80; it++) begin
            logic [N-1:0] an;
            logic [6:0]   seg;
            int r, q;
            r = $urandom_range(0, 9);
            if (r < 7)       an = ~(4'b0001 << $urandom_range(0, N - 1));
            else if (r == 7) an = '1;
            else             an = 4'($urandom_range(0, 15));
            q = $urandom_range(0, 9);
            if (q < 7)       seg = seg_tab[$urandom_range(0, 15)];
            else if (q == 7) seg = 7'h00;
            else             seg = 7'($urandom_range(0, 127));
            hold(an, seg, $urandom_range(1, 9), ($urandom_range(0, 7) == 0));
        end
        hold('1, 7'h00, 4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
